// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG sequencing arbiter.
// Optional feature macro: RNG_ARB_ZERO_GUARD_EN (replace all-zero seeds, reseed a locked LFSR).
package rng_pkg;

  localparam int unsigned RNG_WIDTH = 24;
  localparam logic [RNG_WIDTH-1:0] RNG_SAFE_SEED = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MIX  = 2'd2
  } state_e;

  // Seed actually captured for a requested seed value; zero would lock the LFSR.
  function automatic logic [RNG_WIDTH-1:0] seed_guard(input logic [RNG_WIDTH-1:0] s);
`ifdef RNG_ARB_ZERO_GUARD_EN
    return (s == '0) ? RNG_SAFE_SEED : s;
`else
    return s;
`endif
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit above ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_vld
);

  int unsigned cand;
  logic [PTR_W-1:0] cand_idx;

  // Scan ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; first hit wins.
  always_comb begin
    win_oh   = '0;
    win_idx  = '0;
    win_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + 32'd1 + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!win_vld && req[cand_idx]) begin
        win_vld           = 1'b1;
        win_idx           = cand_idx;
        win_oh[cand_idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Shares one external 24-bit LFSR among NUM_REQ requesters: loads seeds, mixes
// MIX_SHIFTS steps between served words, and grants round-robin.
// Optional feature macro: RNG_ARB_ZERO_GUARD_EN.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MIX_SHIFTS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_load,
  input  logic [RNG_WIDTH-1:0] seed_in,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [RNG_WIDTH-1:0] rnd_out,
  output logic                 rnd_valid,
  output logic                 busy,
  output logic                 lfsr_shift_en,
  output logic                 lfsr_load_en,
  output logic [RNG_WIDTH-1:0] lfsr_seed,
  input  logic [RNG_WIDTH-1:0] lfsr_value
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MIX_SHIFTS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MIX_SHIFTS);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     mix_cnt_q, mix_cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [RNG_WIDTH-1:0] seed_q, seed_d;
  logic [RNG_WIDTH-1:0] rnd_q, rnd_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 vld_q, vld_d;

  logic [NUM_REQ-1:0]   arb_oh;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_vld;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .win_vld (arb_vld)
  );

  // Next-state and registered-output logic; seed_load preempts everything.
  always_comb begin
    state_d   = state_q;
    mix_cnt_d = mix_cnt_q;
    ptr_d     = ptr_q;
    seed_d    = seed_q;
    rnd_d     = rnd_q;
    gnt_d     = '0;
    vld_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          seed_d  = seed_guard(seed_in);
          state_d = LOAD;
        end
`ifdef RNG_ARB_ZERO_GUARD_EN
        else if (lfsr_value == '0) begin
          seed_d  = RNG_SAFE_SEED;
          state_d = LOAD;
        end
`endif
        else if (arb_vld) begin
          gnt_d     = arb_oh;
          rnd_d     = lfsr_value;
          vld_d     = 1'b1;
          ptr_d     = arb_idx;
          mix_cnt_d = CNT_INIT;
          state_d   = MIX;
        end
      end
      LOAD: begin
        if (seed_load) begin
          seed_d = seed_guard(seed_in);
        end else begin
          mix_cnt_d = CNT_INIT;
          state_d   = MIX;
        end
      end
      MIX: begin
        if (seed_load) begin
          seed_d  = seed_guard(seed_in);
          state_d = LOAD;
        end else begin
          mix_cnt_d = mix_cnt_q - CNT_W'(1);
          if (mix_cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset starts by mixing the LFSR's reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MIX;
      mix_cnt_q <= CNT_INIT;
      ptr_q     <= PTR_INIT;
      seed_q    <= '0;
      rnd_q     <= '0;
      gnt_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mix_cnt_q <= mix_cnt_d;
      ptr_q     <= ptr_d;
      seed_q    <= seed_d;
      rnd_q     <= rnd_d;
      gnt_q     <= gnt_d;
      vld_q     <= vld_d;
    end
  end

  assign gnt           = gnt_q;
  assign rnd_out       = rnd_q;
  assign rnd_valid     = vld_q;
  assign lfsr_seed     = seed_q;
  assign busy          = (state_q != IDLE);
  assign lfsr_shift_en = (state_q == MIX);
  assign lfsr_load_en  = (state_q == LOAD);

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model. Honors RNG_ARB_ZERO_GUARD_EN.
module tb_rng_arbiter;

  localparam int NREQ = 4;
  localparam int MIX  = 24;
`ifdef RNG_ARB_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, seed_load, seed_load1;
  logic [23:0] seed_in, seed_in1;
  logic [3:0]  req, req1;
  logic [3:0]  gnt, gnt1;
  logic [23:0] rnd_out, rnd_out1, lfsr_seed, lfsr_seed1, lfsr, lfsr1;
  logic        rnd_valid, busy, shift_en, load_en;
  logic        rnd_valid1, busy1, shift_en1, load_en1;

  rng_arbiter #(.NUM_REQ(NREQ), .MIX_SHIFTS(MIX)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .gnt(gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .busy(busy),
    .lfsr_shift_en(shift_en), .lfsr_load_en(load_en), .lfsr_seed(lfsr_seed),
    .lfsr_value(lfsr)
  );

  rng_arbiter #(.NUM_REQ(NREQ), .MIX_SHIFTS(1)) dut1 (
    .clk(clk), .rst(rst), .seed_load(seed_load1), .seed_in(seed_in1), .req(req1),
    .gnt(gnt1), .rnd_out(rnd_out1), .rnd_valid(rnd_valid1), .busy(busy1),
    .lfsr_shift_en(shift_en1), .lfsr_load_en(load_en1), .lfsr_seed(lfsr_seed1),
    .lfsr_value(lfsr1)
  );

  function automatic logic [23:0] lfsr_next(input logic [23:0] v);
    return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
  endfunction

  // External LFSRs driven by each arbiter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 24'hFFFFFF;
    else if (load_en) lfsr <= lfsr_seed;
    else if (shift_en) lfsr <= lfsr_next(lfsr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr1 <= 24'hFFFFFF;
    else if (load_en1) lfsr1 <= lfsr_seed1;
    else if (shift_en1) lfsr1 <= lfsr_next(lfsr1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_load = seed pending load, m_left = mix cycles remaining.
  bit          m_load;
  int          m_left;
  int          m_ptr;
  logic [23:0] m_seed, m_lfsr, e_rnd;
  logic [3:0]  e_gnt;
  bit          e_valid;

  function automatic logic [23:0] model_guard(input logic [23:0] s);
    return (ZG && s == 24'h0) ? 24'hFFFFFF : s;
  endfunction

  task automatic model_reset();
    m_load = 1'b0; m_left = MIX; m_ptr = NREQ - 1; m_seed = '0;
    m_lfsr = 24'hFFFFFF; e_gnt = '0; e_valid = 1'b0; e_rnd = '0;
  endtask

  task automatic model_step();
    bit shifting;
    bit found;
    logic [23:0] old;
    shifting = !m_load && (m_left > 0);
    old = m_lfsr;
    if (m_load) m_lfsr = m_seed;
    else if (shifting) m_lfsr = lfsr_next(m_lfsr);
    e_gnt = '0; e_valid = 1'b0;
    if (seed_load) begin
      m_seed = model_guard(seed_in); m_load = 1'b1; m_left = 0;
    end else if (m_load) begin
      m_load = 1'b0; m_left = MIX;
    end else if (shifting) begin
      m_left--;
    end else if (ZG && old == 24'h0) begin
      m_seed = 24'hFFFFFF; m_load = 1'b1;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (!found && req[idx]) begin
          found = 1'b1; m_ptr = idx; e_gnt[idx] = 1'b1;
          e_valid = 1'b1; e_rnd = old; m_left = MIX;
        end
      end
    end
  endtask

  task automatic compare_main();
    chk_eq("gnt",       32'(gnt),       32'(e_gnt));
    chk_eq("rnd_valid", 32'(rnd_valid), 32'(e_valid));
    chk_eq("rnd_out",   32'(rnd_out),   32'(e_rnd));
    chk_eq("busy",      32'(busy),      32'(m_load || m_left > 0));
    chk_eq("shift_en",  32'(shift_en),  32'(!m_load && m_left > 0));
    chk_eq("load_en",   32'(load_en),   32'(m_load));
    chk_eq("lfsr_seed", 32'(lfsr_seed), 32'(m_seed));
    chk_eq("lfsr",      32'(lfsr),      32'(m_lfsr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_main();
  endtask

  // Asynchronous reset pulse between clock edges; values must apply at once.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    compare_main();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 200);
    if (gnt == '0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout got=no_gnt exp=gnt", tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout got=busy exp=idle", tag);
    end
  endtask

  logic [23:0] exp_word;
  int n, n_gr;

  initial begin
    seed_load = 0; seed_in = '0; req = '0;
    seed_load1 = 0; seed_in1 = '0; req1 = '0;
    rst = 1'b1;
    #1;
    do_reset();
    chk_eq("m1_reset_busy", 32'(busy1), 32'd1);
    chk_eq("m1_reset_gnt",  32'(gnt1),  32'd0);

    // MIX_SHIFTS=1 instance: seed 1, one shift, word 2 delivered to req[1].
    tick();
    chk_eq("m1_idle", 32'(busy1), 32'd0);
    seed_load1 = 1'b1; seed_in1 = 24'h000001;
    tick();
    chk_eq("m1_load_en", 32'(load_en1), 32'd1);
    chk_eq("m1_no_shift", 32'(shift_en1), 32'd0);
    seed_load1 = 1'b0;
    tick();
    chk_eq("m1_load_pulse", 32'(load_en1), 32'd0);
    chk_eq("m1_shift", 32'(shift_en1), 32'd1);
    chk_eq("m1_lfsr_seeded", 32'(lfsr1), 32'h000001);
    req1 = 4'b0010;
    tick();
    chk_eq("m1_lfsr_shifted", 32'(lfsr1), 32'h000002);
    chk_eq("m1_gnt_wait", 32'(gnt1), 32'd0);
    tick();
    chk_eq("m1_gnt", 32'(gnt1), 32'b0010);
    chk_eq("m1_valid", 32'(rnd_valid1), 32'd1);
    chk_eq("m1_rnd", 32'(rnd_out1), 32'h000002);
    req1 = '0;
    tick();
    chk_eq("m1_valid_pulse", 32'(rnd_valid1), 32'd0);

    // First grant after reset: 24 mix cycles, word is 24 shifts past all-ones.
    do_reset();
    req = 4'b0001;
    wait_gnt("first", n);
    chk_eq("first_gnt_lat", 32'(n), 32'(MIX + 1));
    exp_word = 24'hFFFFFF;
    for (int i = 0; i < MIX; i++) exp_word = lfsr_next(exp_word);
    chk_eq("first_word", 32'(rnd_out), 32'(exp_word));
    chk_eq("first_gnt", 32'(gnt), 32'b0001);
    req = '0;

    // All requesters held: strict rotation, MIX+1 cycles apart.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_gnt("rot", n);
      chk_eq("rot_gap", 32'(n), 32'(MIX + 1));
      chk_eq("rot_gnt", 32'(gnt), 32'(1 << (k % NREQ)));
    end
    req = '0;

    // Seed load in mid-mix: shifting stops, load pulses, full mix restarts.
    repeat (5) tick();
    seed_load = 1'b1; seed_in = 24'h5A5A5A;
    tick();
    chk_eq("abort_no_shift", 32'(shift_en), 32'd0);
    chk_eq("abort_load", 32'(load_en), 32'd1);
    seed_load = 1'b0;
    tick();
    chk_eq("abort_shift", 32'(shift_en), 32'd1);
    chk_eq("abort_lfsr", 32'(lfsr), 32'h5A5A5A);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk_eq("abort_mix_len", 32'(n), 32'(MIX));

    // Seed load and request together in IDLE: seed wins, grant after the mix.
    seed_load = 1'b1; seed_in = 24'h000001; req = 4'b0100;
    tick();
    chk_eq("same_no_gnt", 32'(gnt), 32'd0);
    chk_eq("same_load", 32'(load_en), 32'd1);
    seed_load = 1'b0;
    wait_gnt("same", n);
    chk_eq("same_gnt_lat", 32'(n), 32'(MIX + 2));
    chk_eq("same_gnt", 32'(gnt), 32'b0100);
    exp_word = 24'h000001;
    for (int i = 0; i < MIX; i++) exp_word = lfsr_next(exp_word);
    chk_eq("same_word", 32'(rnd_out), 32'(exp_word));
    req = '0;

    // All-zero seed handling.
    wait_idle("zero_pre");
    seed_load = 1'b1; seed_in = 24'h0;
    tick();
    seed_load = 1'b0;
    chk_eq("zero_seed_reg", 32'(lfsr_seed), ZG ? 32'hFFFFFF : 32'h0);
    wait_idle("zero_mix");
    req = 4'b0001;
    wait_gnt("zero", n);
    if (ZG) chk_eq("zero_word_nonzero", 32'(rnd_out != 24'h0), 32'd1);
    else    chk_eq("zero_word", 32'(rnd_out), 32'h0);
    req = '0;

    // Random traffic with occasional reseeds, zero seeds and one mid-run reset.
    n_gr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      seed_load = ($urandom_range(0, 63) == 0);
      seed_in = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
      end
      tick();
      if (gnt != '0) n_gr++;
    end
    chk_eq("rand_grants_seen", 32'(n_gr > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
